eoc_monitor: RTL and testbench

EOC_MONITOR -- requirements
Module: eoc_monitor

---
 rtl/eoc_monitor.sv | 114 +++++++++++
 tb/tb_eoc_monitor.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/eoc_monitor.sv
// rtl/eoc_monitor.sv - end-of-computation / watchdog monitor snooping a write-request channel
module eoc_monitor #(
  parameter int unsigned          AddrWidth     = 48,
  parameter logic [AddrWidth-1:0] EocAddr       = 48'h0300_0008,
  parameter logic [31:0]          TimeoutCycles = 32'd10_000_000
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 en_i,
  input  logic                 req_valid_i,
  input  logic                 req_ready_i,
  input  logic                 req_write_i,
  input  logic [AddrWidth-1:0] req_addr_i,
  input  logic [31:0]          req_data_i,
  input  logic [3:0]           req_strb_i,
  output logic                 eoc_o,
  output logic                 timeout_o,
  output logic [31:0]          exit_code_o,
  output logic                 busy_o,
  output logic [15:0]          hb_count_o
);

  typedef enum logic [1:0] {IDLE, RUN, DONE, TIMEOUT} state_t;

  state_t      state_q, state_d;
  logic [31:0] cnt_q, cnt_d;
  logic [15:0] hb_d;
  logic [31:0] exit_d;
  logic        eoc_d, timeout_d, busy_d;

  logic qual, eoc_hit, hb_hit, expire;

  // Only a completed handshake of a full-word write to the scratch register counts.
  assign qual    = req_valid_i & req_ready_i & req_write_i &
                   (req_addr_i == EocAddr) & (req_strb_i == 4'hF);
  assign eoc_hit = qual &  req_data_i[0];
  assign hb_hit  = qual & ~req_data_i[0];
  assign expire  = (TimeoutCycles != 32'd0) && (cnt_q == TimeoutCycles - 32'd1);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      hb_count_o  <= '0;
      exit_code_o <= '0;
      eoc_o       <= 1'b0;
      timeout_o   <= 1'b0;
      busy_o      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      hb_count_o  <= hb_d;
      exit_code_o <= exit_d;
      eoc_o       <= eoc_d;
      timeout_o   <= timeout_d;
      busy_o      <= busy_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (!en_i) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE:    state_d = RUN;
        RUN: begin
          if (eoc_hit)               state_d = DONE;
          else if (!hb_hit && expire) state_d = TIMEOUT;
        end
        default: state_d = state_q;
      endcase
    end
  end

  // Result registers are sticky: only arming clears them, disarming keeps them readable.
  always_comb begin
    cnt_d     = cnt_q;
    hb_d      = hb_count_o;
    exit_d    = exit_code_o;
    eoc_d     = eoc_o;
    timeout_d = timeout_o;
    if (!en_i) begin
      cnt_d = '0;
    end else begin
      case (state_q)
        IDLE: begin
          cnt_d     = '0;
          hb_d      = '0;
          exit_d    = '0;
          eoc_d     = 1'b0;
          timeout_d = 1'b0;
        end
        RUN: begin
          if (eoc_hit) begin
            eoc_d  = 1'b1;
            exit_d = {1'b0, req_data_i[31:1]};
          end else if (hb_hit) begin
            cnt_d = '0;
            hb_d  = (hb_count_o == 16'hFFFF) ? hb_count_o : hb_count_o + 16'd1;
          end else if (expire) begin
            timeout_d = 1'b1;
            exit_d    = 32'hFFFF_FFFF;
          end else begin
            cnt_d = cnt_q + 32'd1;
          end
        end
        default: ;
      endcase
    end
    busy_d = (state_d == RUN);
  end

endmodule

// File: tb/tb_eoc_monitor.sv
// tb/tb_eoc_monitor.sv - directed scoreboard bench for eoc_monitor
module tb_eoc_monitor;

  localparam logic [47:0] EOC_ADDR = 48'h0300_0008;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b1;
  logic        en_i = 1'b0;
  logic        req_valid_i = 1'b0;
  logic        req_ready_i = 1'b0;
  logic        req_write_i = 1'b0;
  logic [47:0] req_addr_i = '0;
  logic [31:0] req_data_i = '0;
  logic [3:0]  req_strb_i = '0;
  logic        eoc_o, timeout_o, busy_o;
  logic [31:0] exit_code_o;
  logic [15:0] hb_count_o;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic        eoc;
    logic        to;
    logic [31:0] code;
    logic [15:0] hb;
    int          lat;
  } exp_t;
  exp_t sb[$];

  eoc_monitor #(
    .AddrWidth(48),
    .EocAddr(EOC_ADDR),
    .TimeoutCycles(32'd100)
  ) dut (
    .clk_i(clk_i),
    .rst_i(rst_i),
    .en_i(en_i),
    .req_valid_i(req_valid_i),
    .req_ready_i(req_ready_i),
    .req_write_i(req_write_i),
    .req_addr_i(req_addr_i),
    .req_data_i(req_data_i),
    .req_strb_i(req_strb_i),
    .eoc_o(eoc_o),
    .timeout_o(timeout_o),
    .exit_code_o(exit_code_o),
    .busy_o(busy_o),
    .hb_count_o(hb_count_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic tick(input int n);
    repeat (n) @(posedge clk_i);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic wr(input logic [47:0] addr, input logic [31:0] data,
                    input logic [3:0] strb, input logic wr_en);
    req_valid_i = 1'b1;
    req_ready_i = 1'b1;
    req_write_i = wr_en;
    req_addr_i  = addr;
    req_data_i  = data;
    req_strb_i  = strb;
    tick(1);
    req_valid_i = 1'b0;
    req_ready_i = 1'b0;
    req_write_i = 1'b0;
  endtask

  task automatic arm(input string tag);
    en_i = 1'b1;
    tick(1);
    chk({tag, "_busy"}, {31'd0, busy_o}, 32'd1);
    chk({tag, "_eoc"}, {31'd0, eoc_o}, 32'd0);
    chk({tag, "_hb"}, {16'd0, hb_count_o}, 32'd0);
  endtask

  task automatic disarm();
    en_i = 1'b0;
    tick(1);
  endtask

  task automatic push(input logic eoc, input logic to, input logic [31:0] code,
                      input logic [15:0] hb, input int lat);
    exp_t e;
    e.eoc = eoc; e.to = to; e.code = code; e.hb = hb; e.lat = lat;
    sb.push_back(e);
  endtask

  task automatic wait_result(input string tag);
    exp_t e;
    int   n = 0;
    while (!(eoc_o || timeout_o) && n < 300) begin
      tick(1);
      n++;
    end
    e = sb.pop_front();
    chk({tag, "_lat"}, n, e.lat);
    chk({tag, "_eoc"}, {31'd0, eoc_o}, {31'd0, e.eoc});
    chk({tag, "_to"}, {31'd0, timeout_o}, {31'd0, e.to});
    chk({tag, "_code"}, exit_code_o, e.code);
    chk({tag, "_hb"}, {16'd0, hb_count_o}, {16'd0, e.hb});
    chk({tag, "_busy"}, {31'd0, busy_o}, 32'd0);
  endtask

  initial begin
    #3;
    chk("rst_eoc", {31'd0, eoc_o}, 32'd0);
    chk("rst_to", {31'd0, timeout_o}, 32'd0);
    chk("rst_code", exit_code_o, 32'd0);
    chk("rst_busy", {31'd0, busy_o}, 32'd0);
    chk("rst_hb", {16'd0, hb_count_o}, 32'd0);
    tick(2);
    rst_i = 1'b0;
    tick(2);
    chk("idle_busy", {31'd0, busy_o}, 32'd0);

    // basic EOC with exit code 0
    arm("t1_arm");
    push(1'b1, 1'b0, 32'd0, 16'd0, 0);
    wr(EOC_ADDR, 32'h0000_0001, 4'hF, 1'b1);
    wait_result("t1");
    disarm();
    chk("t1_idle_eoc", {31'd0, eoc_o}, 32'd1);
    chk("t1_idle_busy", {31'd0, busy_o}, 32'd0);

    // ignored partial strobe, read, other address; then EOC 0x55
    arm("t2_arm");
    wr(EOC_ADDR, 32'h0000_0055, 4'h3, 1'b1);
    wr(EOC_ADDR, 32'h0000_0001, 4'hF, 1'b0);
    wr(EOC_ADDR + 48'd8, 32'h0000_0001, 4'hF, 1'b1);
    chk("t2_ign_eoc", {31'd0, eoc_o}, 32'd0);
    chk("t2_ign_hb", {16'd0, hb_count_o}, 32'd0);
    chk("t2_ign_busy", {31'd0, busy_o}, 32'd1);
    push(1'b1, 1'b0, 32'h0000_002A, 16'd0, 0);
    wr(EOC_ADDR, 32'h0000_0055, 4'hF, 1'b1);
    wait_result("t2");
    wr(EOC_ADDR, 32'h0000_0099, 4'hF, 1'b1);
    chk("t2_hold_code", exit_code_o, 32'h0000_002A);
    disarm();

    // plain timeout, 100 cycles after arming
    arm("t3_arm");
    push(1'b0, 1'b1, 32'hFFFF_FFFF, 16'd0, 100);
    wait_result("t3");
    disarm();

    // heartbeat at cycle 50 pushes timeout to cycle 150
    arm("t4_arm");
    tick(49);
    wr(EOC_ADDR, 32'h0000_0002, 4'hF, 1'b1);
    chk("t4_hb", {16'd0, hb_count_o}, 32'd1);
    push(1'b0, 1'b1, 32'hFFFF_FFFF, 16'd1, 100);
    wait_result("t4");
    disarm();

    // EOC on the expiring edge wins
    arm("t5_arm");
    tick(99);
    push(1'b1, 1'b0, 32'h0000_0008, 16'd0, 0);
    wr(EOC_ADDR, 32'h0000_0011, 4'hF, 1'b1);
    wait_result("t5");
    disarm();

    // stalled request captured once on handshake
    arm("t6_arm");
    req_valid_i = 1'b1;
    req_ready_i = 1'b0;
    req_write_i = 1'b1;
    req_addr_i  = EOC_ADDR;
    req_data_i  = 32'h0000_0003;
    req_strb_i  = 4'hF;
    tick(10);
    chk("t6_stall_eoc", {31'd0, eoc_o}, 32'd0);
    push(1'b1, 1'b0, 32'h0000_0001, 16'd0, 0);
    req_ready_i = 1'b1;
    tick(1);
    req_valid_i = 1'b0;
    req_ready_i = 1'b0;
    wait_result("t6");
    disarm();

    // async reset mid-RUN, then DONE retention through disarm
    arm("t7_arm");
    wr(EOC_ADDR, 32'h0000_0004, 4'hF, 1'b1);
    tick(4);
    #2 rst_i = 1'b1;
    #1;
    chk("t7_rst_busy", {31'd0, busy_o}, 32'd0);
    chk("t7_rst_hb", {16'd0, hb_count_o}, 32'd0);
    chk("t7_rst_code", exit_code_o, 32'd0);
    #2 rst_i = 1'b0;
    tick(1);
    chk("t7_rearm_busy", {31'd0, busy_o}, 32'd1);
    push(1'b1, 1'b0, 32'h0000_0002, 16'd0, 0);
    wr(EOC_ADDR, 32'h0000_0005, 4'hF, 1'b1);
    wait_result("t7");
    disarm();
    tick(3);
    chk("t7_idle_eoc", {31'd0, eoc_o}, 32'd1);
    chk("t7_idle_code", exit_code_o, 32'h0000_0002);
    arm("t7_rearm2");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
